// File: rtl/wam_pkg.sv
// wam_pkg: game-state encodings, segment patterns and decoder digit codes shared by
// the game core and the display driver.
package wam_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        GAMEPLAY   = 3'd1,
        END_SCREEN = 3'd2
    } game_state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    // Decoder codes above the decimal range
    localparam logic [3:0] DIG_BLANK = 4'hA;
    localparam logic [3:0] DIG_DASH  = 4'hB;
    localparam logic [3:0] DIG_E     = 4'hC;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational digit-code to active-low seven-segment pattern
// (0-9, blank, dash, E).
module seg7_decode
    import wam_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:     seg = 7'b1000000;
            4'd1:     seg = 7'b1111001;
            4'd2:     seg = 7'b0100100;
            4'd3:     seg = 7'b0110000;
            4'd4:     seg = 7'b0011001;
            4'd5:     seg = 7'b0010010;
            4'd6:     seg = 7'b0000010;
            4'd7:     seg = 7'b1111000;
            4'd8:     seg = 7'b0000000;
            4'd9:     seg = 7'b0010000;
            DIG_DASH: seg = SEG_DASH;
            DIG_E:    seg = SEG_E;
            default:  seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/wam_display_driver.sv
// wam_display_driver: multiplexed 4-digit display of lives/score with frame-coherent
// snapshots. Define WAM_BLINK_EN to blink the display on the end screen.
module wam_display_driver
    import wam_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mole,
    input  logic [3:0] score,
    input  logic [3:0] lives,
    input  logic [2:0] state,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [RW-1:0] cnt;
    logic [1:0]    idx;
    logic          tick;
    logic          wrap;
    logic          snap_mole;
    logic [3:0]    snap_score;
    logic [3:0]    snap_lives;
    logic [2:0]    snap_state;
    logic [3:0]    val;
    logic [3:0]    tens;
    logic [3:0]    units;
    logic [3:0]    digit;
    logic [6:0]    seg_next;
    logic          blank;

    assign tick = cnt == RW'(REFRESH_DIV - 1);
    assign wrap = tick && idx == 2'd3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            idx <= 2'd0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick)
                idx <= idx + 2'd1;
        end
    end

    // Snapshots change only at frame boundaries so a frame never mixes values
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_mole  <= 1'b0;
            snap_score <= 4'd0;
            snap_lives <= 4'd0;
            snap_state <= IDLE;
        end else if (wrap) begin
            snap_mole  <= mole;
            snap_score <= score;
            snap_lives <= lives;
            snap_state <= state;
        end
    end

    always_comb begin
        val   = idx[1] ? snap_lives : snap_score;
        tens  = (val >= 4'd10) ? 4'd1 : DIG_BLANK;
        units = (val >= 4'd10) ? 4'(val - 4'd10) : val;
        digit = (snap_state == IDLE) ? DIG_DASH :
                (snap_state == GAMEPLAY || snap_state == END_SCREEN) ? (idx[0] ? tens : units) :
                DIG_E;
    end

    seg7_decode u_dec (
        .digit (digit),
        .seg   (seg_next)
    );

`ifdef WAM_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] bcnt;
    logic          blink;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcnt  <= '0;
            blink <= 1'b0;
        end else if (tick) begin
            if (snap_state == END_SCREEN) begin
                if (bcnt == BW'(BLINK_DIV - 1)) begin
                    bcnt  <= '0;
                    blink <= ~blink;
                end else begin
                    bcnt <= bcnt + 1'b1;
                end
            end else begin
                bcnt  <= '0;
                blink <= 1'b0;
            end
        end
    end

    // Gated by state so a stale flag cannot blank the first frame after leaving
    assign blank = blink && snap_state == END_SCREEN;
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= blank ? 4'b1111 : ~(4'b0001 << idx);
            seg <= seg_next;
            dp  <= !(idx == 2'd0 && snap_mole && snap_state == GAMEPLAY);
        end
    end

endmodule
